// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the async program ROM into an IR and
// issues opcode/operand over valid/ready. Optional FETCH_STATS_EN adds retired_cnt.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 13,
  parameter int unsigned OP_W = 3,
  parameter logic [OP_W-1:0] JMP_OP = 3'b110,
  parameter logic [OP_W-1:0] HALT_OP = 3'b111,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic [ADDR_W-1:0]      pm_addr,
  input  logic [DATA_W-1:0]      pm_data,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [OP_W-1:0]        opcode,
  output logic [DATA_W-OP_W-1:0] operand,
  output logic [ADDR_W-1:0]      instr_pc,
  input  logic                   jump_req,
  input  logic [ADDR_W-1:0]      jump_addr,
`ifdef FETCH_STATS_EN
  output logic [15:0]            retired_cnt,
`endif
  output logic                   halted
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    ISSUE  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic              handshake;

  assign pm_addr   = pc;
  assign opcode    = ir[DATA_W-1 -: OP_W];
  assign operand   = ir[DATA_W-OP_W-1:0];
  assign handshake = (state == ISSUE) && instr_ready;

  // Fetch/issue/halt sequencer; a redirect always beats the internal JMP/HALT decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      ir          <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (en) begin
      case (state)
        FETCH: begin
          if (jump_req) begin
            pc <= jump_addr;
          end else begin
            ir          <= pm_data;
            instr_pc    <= pc;
            pc          <= ADDR_W'(pc + ADDR_W'(1));
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (jump_req) begin
            pc          <= jump_addr;
            instr_valid <= 1'b0;
            state       <= FETCH;
          end else if (handshake) begin
            instr_valid <= 1'b0;
            if (opcode == HALT_OP) begin
              halted <= 1'b1;
              state  <= HALTED;
            end else begin
              if (opcode == JMP_OP) pc <= operand[ADDR_W-1:0];
              state <= FETCH;
            end
          end
        end
        HALTED: begin
          instr_valid <= 1'b0;
          halted      <= 1'b1;
        end
        default: begin
          instr_valid <= 1'b0;
          state       <= FETCH;
        end
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  // Saturating count of accepted instructions, including those accepted alongside a redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_cnt <= '0;
    end else if (en && handshake && (retired_cnt != 16'hFFFF)) begin
      retired_cnt <= retired_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; define FETCH_STATS_EN to also check retired_cnt.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  pm_addr;
  logic [12:0] pm_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  opcode;
  logic [9:0]  operand;
  logic [7:0]  instr_pc;
  logic        jump_req;
  logic [7:0]  jump_addr;
  logic        halted;
`ifdef FETCH_STATS_EN
  logic [15:0] retired_cnt;
`endif

  logic [12:0] rom [256];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign pm_data = rom[pm_addr];

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pm_addr(pm_addr), .pm_data(pm_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .opcode(opcode),
    .operand(operand), .instr_pc(instr_pc), .jump_req(jump_req),
    .jump_addr(jump_addr),
`ifdef FETCH_STATS_EN
    .retired_cnt(retired_cnt),
`endif
    .halted(halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Advance until instr_valid is seen at a sampling point, bounded.
  task automatic wait_valid(input string tag);
    int n = 0;
    while (!instr_valid && n < 8) begin
      step();
      n++;
    end
    chk({tag, " valid"}, 32'(instr_valid), 32'd1);
  endtask

  task automatic chk_instr(input string tag, input logic [7:0] pc, input logic [2:0] op,
                           input logic [9:0] opnd);
    wait_valid(tag);
    chk({tag, " pc"}, 32'(instr_pc), 32'(pc));
    chk({tag, " op"}, 32'(opcode), 32'(op));
    chk({tag, " opnd"}, 32'(operand), 32'(opnd));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[0] = 13'b000_0000000001;
    rom[1] = 13'b001_0000000010;
    rom[2] = 13'b010_0000000100;
    rom[3] = 13'b111_0000000000;
    rst_n = 1'b0; en = 1'b1; instr_ready = 1'b1; jump_req = 1'b0; jump_addr = 8'h00;
    @(negedge clk);

    // 1) straight-line run to HALT
    do_reset();
    chk("rst valid", 32'(instr_valid), 32'd0);
    chk("rst halted", 32'(halted), 32'd0);
    chk("rst pm_addr", 32'(pm_addr), 32'h00);
    chk("rst instr_pc", 32'(instr_pc), 32'h00);
    chk("rst opcode", 32'(opcode), 32'd0);
    chk_instr("s1 i0", 8'h00, 3'd0, 10'd1); step();
    chk_instr("s1 i1", 8'h01, 3'd1, 10'd2); step();
    chk_instr("s1 i2", 8'h02, 3'd2, 10'd4); step();
    chk_instr("s1 i3", 8'h03, 3'd7, 10'd0); step();
    chk("s1 halted", 32'(halted), 32'd1);
    chk("s1 valid off", 32'(instr_valid), 32'd0);
    chk("s1 pm_addr", 32'(pm_addr), 32'h04);
    jump_req = 1'b1; jump_addr = 8'h55;
    step(); step(); step();
    jump_req = 1'b0;
    chk("s1 halt pm_addr", 32'(pm_addr), 32'h04);
    chk("s1 halt stays", 32'(halted), 32'd1);
    chk("s1 halt valid", 32'(instr_valid), 32'd0);
`ifdef FETCH_STATS_EN
    chk("s1 retired", 32'(retired_cnt), 32'd4);
`endif

    // 2) back-pressure at pc1
    instr_ready = 1'b0;
    do_reset();
    chk("s2 reset halted", 32'(halted), 32'd0);
    chk_instr("s2 i0", 8'h00, 3'd0, 10'd1);
    instr_ready = 1'b1; step(); instr_ready = 1'b0;
    chk_instr("s2 i1", 8'h01, 3'd1, 10'd2);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("s2 hold valid", 32'(instr_valid), 32'd1);
      chk("s2 hold op", 32'(opcode), 32'd1);
      chk("s2 hold opnd", 32'(operand), 32'd2);
      chk("s2 hold pm_addr", 32'(pm_addr), 32'h02);
    end
    instr_ready = 1'b1; step();
    chk("s2 accept", 32'(instr_valid), 32'd0);

    // 3) redirect during ISSUE of pc0
    instr_ready = 1'b0;
    do_reset();
    chk_instr("s3 i0", 8'h00, 3'd0, 10'd1);
    jump_req = 1'b1; jump_addr = 8'h02; step(); jump_req = 1'b0;
    chk("s3 valid drop", 32'(instr_valid), 32'd0);
    chk("s3 pm_addr", 32'(pm_addr), 32'h02);
    chk_instr("s3 tgt", 8'h02, 3'd2, 10'd4);

    // 4) internal JMP 3
    rom[0] = 13'b110_0000000011;
    instr_ready = 1'b1;
    do_reset();
    chk_instr("s4 jmp", 8'h00, 3'd6, 10'd3); step();
    chk("s4 pm_addr", 32'(pm_addr), 32'h03);
    chk_instr("s4 tgt", 8'h03, 3'd7, 10'd0); step();
    chk("s4 halted", 32'(halted), 32'd1);
    rom[0] = 13'b000_0000000001;

    // 5) redirect beats HALT on the same handshake
    do_reset();
    chk_instr("s5 i0", 8'h00, 3'd0, 10'd1); step();
    chk_instr("s5 i1", 8'h01, 3'd1, 10'd2); step();
    chk_instr("s5 i2", 8'h02, 3'd2, 10'd4); step();
    chk_instr("s5 i3", 8'h03, 3'd7, 10'd0);
    jump_req = 1'b1; jump_addr = 8'h00; step(); jump_req = 1'b0;
    chk("s5 no halt", 32'(halted), 32'd0);
    chk("s5 valid drop", 32'(instr_valid), 32'd0);
    chk("s5 pm_addr", 32'(pm_addr), 32'h00);
    chk_instr("s5 refetch", 8'h00, 3'd0, 10'd1);
`ifdef FETCH_STATS_EN
    chk("s5 retired", 32'(retired_cnt), 32'd4);
`endif

    // 6) PC wrap and reset in ISSUE
    instr_ready = 1'b0;
    do_reset();
    chk_instr("s6 i0", 8'h00, 3'd0, 10'd1);
    jump_req = 1'b1; jump_addr = 8'hFF; step(); jump_req = 1'b0;
    chk("s6 pm_addr ff", 32'(pm_addr), 32'hFF);
    step();
    chk("s6 pc ff", 32'(instr_pc), 32'hFF);
    chk("s6 wrap", 32'(pm_addr), 32'h00);
    chk("s6 valid", 32'(instr_valid), 32'd1);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("s6 rst valid", 32'(instr_valid), 32'd0);
    chk("s6 rst pm_addr", 32'(pm_addr), 32'h00);
    chk("s6 rst instr_pc", 32'(instr_pc), 32'h00);

    // 7) en=0 freezes ISSUE and ignores ready/jump
    do_reset();
    chk_instr("s7 i0", 8'h00, 3'd0, 10'd1);
    en = 1'b0; instr_ready = 1'b1; jump_req = 1'b1; jump_addr = 8'h40;
    step(); step(); step();
    chk("s7 stall valid", 32'(instr_valid), 32'd1);
    chk("s7 stall pm_addr", 32'(pm_addr), 32'h01);
    chk("s7 stall pc", 32'(instr_pc), 32'h00);
`ifdef FETCH_STATS_EN
    chk("s7 stall retired", 32'(retired_cnt), 32'd0);
`endif
    en = 1'b1; jump_req = 1'b0; step();
    chk("s7 resume accept", 32'(instr_valid), 32'd0);

    // 8) redirect in FETCH discards the IR load
    instr_ready = 1'b0;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    jump_req = 1'b1; jump_addr = 8'h03; step(); jump_req = 1'b0;
    chk("s8 no issue", 32'(instr_valid), 32'd0);
    chk("s8 pm_addr", 32'(pm_addr), 32'h03);
    chk_instr("s8 tgt", 8'h03, 3'd7, 10'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
